// File: rtl/pixel_write_buffer.sv
// Buffers plot requests in a small FIFO and turns each into one video-memory write; also runs a screen-clear sweep.
// Optional feature macro PWB_CLIP_EN: drop off-screen requests and count them in clip_count.
module pixel_write_buffer #(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [2:0]  in_colour,
  input  logic        in_plot,
  output logic        in_ready,
  input  logic        clear_req,
  input  logic [2:0]  clear_colour,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        mem_we,
  output logic        busy,
  output logic [7:0]  clip_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   EMPTY_C = {(AW+1){1'b0}};
  localparam logic [AW:0]   ONE_C   = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PINC_C  = AW'(1'b1);
  localparam logic [14:0]   LAST_C  = 15'(SCREEN_W * SCREEN_H - 1);

  typedef enum logic {RUN = 1'b0, CLEAR = 1'b1} state_t;

  state_t        state_r, state_nxt_s;
  logic [17:0]   fifo_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_inc_s;
  logic [AW:0]   count_r;
  logic [14:0]   sweep_r, mem_addr_r;
  logic [2:0]    clr_colour_r, mem_data_r;
  logic          mem_we_r;
  logic          full_s, push_s, pop_s, take_clear_s, clip_s;
  logic [7:0]    head_x_s;
  logic [6:0]    head_y_s;
  logic [2:0]    head_c_s;

  // y*160+x built from shifts so no multiplier is needed
  function automatic logic [14:0] pix_addr(input logic [6:0] y, input logic [7:0] x);
    pix_addr = ({8'd0, y} << 3'd7) + ({8'd0, y} << 3'd5) + {7'd0, x};
  endfunction

  assign full_s       = (count_r == FULL_C);
  assign in_ready     = !full_s;
  assign push_s       = in_plot && !full_s && !clip_s;
  assign pop_s        = (state_r == RUN) && !clear_req && (count_r != EMPTY_C);
  assign wr_ptr_inc_s = wr_ptr_r + PINC_C;
  assign {head_x_s, head_y_s, head_c_s} = fifo_r[rd_ptr_r];

  assign mem_addr = mem_addr_r;
  assign mem_data = mem_data_r;
  assign mem_we   = mem_we_r;
  assign busy     = (state_r == CLEAR) || (count_r != EMPTY_C) || mem_we_r;

`ifdef PWB_CLIP_EN
  localparam logic [7:0] W_C = 8'(SCREEN_W);
  localparam logic [6:0] H_C = 7'(SCREEN_H);
  logic [7:0] clip_cnt_r;

  assign clip_s     = (in_x >= W_C) || (in_y >= H_C);
  assign clip_count = clip_cnt_r;

  // Saturating count of consumed off-screen requests
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clip_cnt_r <= 8'd0;
    end else if (in_plot && !full_s && clip_s && (clip_cnt_r != 8'hFF)) begin
      clip_cnt_r <= clip_cnt_r + 8'd1;
    end
  end
`else
  assign clip_s     = 1'b0;
  assign clip_count = 8'd0;
`endif

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= {in_x, in_y, in_colour};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: a clear request is only honoured from RUN
  always_comb begin
    state_nxt_s  = state_r;
    take_clear_s = 1'b0;
    case (state_r)
      RUN: begin
        if (clear_req) begin
          state_nxt_s  = CLEAR;
          take_clear_s = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      CLEAR: begin
        if (sweep_r == LAST_C) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // Pointers, occupancy, sweep and the registered memory write port
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= EMPTY_C;
      sweep_r      <= 15'd0;
      clr_colour_r <= 3'd0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 15'd0;
      mem_data_r   <= 3'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_inc_s;
      end
      if (take_clear_s) begin
        // flush also swallows a push landing on this very edge
        count_r      <= EMPTY_C;
        rd_ptr_r     <= push_s ? wr_ptr_inc_s : wr_ptr_r;
        clr_colour_r <= clear_colour;
        sweep_r      <= 15'd0;
      end else begin
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PINC_C;
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + ONE_C;
          2'b01:   count_r <= count_r - ONE_C;
          default: count_r <= count_r;
        endcase
      end
      if (state_r == CLEAR) begin
        mem_we_r   <= 1'b1;
        mem_addr_r <= sweep_r;
        mem_data_r <= clr_colour_r;
        sweep_r    <= sweep_r + 15'd1;
      end else if (pop_s) begin
        mem_we_r   <= 1'b1;
        mem_addr_r <= pix_addr(head_y_s, head_x_s);
        mem_data_r <= head_c_s;
      end else begin
        mem_we_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Scoreboard bench for pixel_write_buffer: a transaction-level model predicts every memory write.
module tb_pixel_write_buffer;

  localparam int DEPTH = 8;
  localparam int W     = 160;
  localparam int H     = 120;
  localparam int NPIX  = W * H;
  localparam int LIMIT = 25000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_colour;
  logic        in_plot;
  logic        in_ready;
  logic        clear_req;
  logic [2:0]  clear_colour;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        busy;
  logic [7:0]  clip_count;

  pixel_write_buffer dut (
    .clk(clk), .resetn(resetn), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .in_plot(in_plot), .in_ready(in_ready), .clear_req(clear_req), .clear_colour(clear_colour),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .busy(busy), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int d;
  } wr_t;

  wr_t pend[$];    // requests accepted but not yet written
  wr_t exp_q[$];   // writes expected on the memory port, in order
  bit  m_clear;
  int  m_sweep;
  int  m_col;
  int  m_clip;
  bit  mon_en = 1'b0;
  int  n_checks = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 60) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction per clock edge, written from the behavioural rules
  always @(posedge clk) begin
    bit  acc, clipd;
    wr_t e;
    if (!resetn) begin
      pend.delete();
      exp_q.delete();
      m_clear = 1'b0;
      m_sweep = 0;
      m_clip  = 0;
    end else begin
      acc   = in_plot && (pend.size() < DEPTH);
      clipd = 1'b0;
`ifdef PWB_CLIP_EN
      clipd = (int'(in_x) >= W) || (int'(in_y) >= H);
`endif
      if (acc && clipd && m_clip < 255) m_clip++;
      e.a = (int'(in_y) * W + int'(in_x)) % 32768;
      e.d = int'(in_colour);
      if (!m_clear && clear_req) begin
        pend.delete();
        m_clear = 1'b1;
        m_sweep = 0;
        m_col   = int'(clear_colour);
      end else begin
        if (m_clear) begin
          exp_q.push_back('{a: m_sweep, d: m_col});
          m_sweep++;
          if (m_sweep == NPIX) m_clear = 1'b0;
        end else if (pend.size() != 0) begin
          exp_q.push_back(pend.pop_front());
        end
        if (acc && !clipd) pend.push_back(e);
      end
    end
  end

  // Monitor: compares the port against the scoreboard half a cycle after each edge
  always @(negedge clk) begin
    wr_t e;
    if (mon_en) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, pend.size() < DEPTH});
      chk("busy", {31'd0, busy}, {31'd0, m_clear || pend.size() != 0 || exp_q.size() != 0});
      chk("clip_count", {24'd0, clip_count}, m_clip);
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {17'd0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("mem_addr", {17'd0, mem_addr}, e.a);
          chk("mem_data", {29'd0, mem_data}, e.d);
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("missing_write", {31'd0, mem_we}, 32'd1);
      end
    end
  end

  // Called at a negedge: present a plot and hold it until the edge that accepts it
  task automatic send(input int x, input int y, input int c);
    int k;
    in_x      = 8'(x);
    in_y      = 7'(y);
    in_colour = 3'(c);
    in_plot   = 1'b1;
    k = 0;
    while (!in_ready && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle();
    in_plot = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; in_x = 8'd0; in_y = 7'd0; in_colour = 3'd0; in_plot = 1'b0;
    clear_req = 1'b0; clear_colour = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_mem_we",   {31'd0, mem_we},     32'd0);
    chk("rst_mem_addr", {17'd0, mem_addr},   32'd0);
    chk("rst_mem_data", {29'd0, mem_data},   32'd0);
    chk("rst_busy",     {31'd0, busy},       32'd0);
    chk("rst_in_ready", {31'd0, in_ready},   32'd1);
    chk("rst_clip",     {24'd0, clip_count}, 32'd0);
    mon_en = 1'b1;
    resetn = 1'b1;
    @(negedge clk);

    // single plot: write appears for exactly the cycle after the pop edge
    send(3, 2, 5);
    idle();
    @(negedge clk);
    chk("t1_we",   {31'd0, mem_we},   32'd1);
    chk("t1_addr", {17'd0, mem_addr}, 32'd323);
    chk("t1_data", {29'd0, mem_data}, 32'd5);
    @(negedge clk);
    chk("t1_we_off", {31'd0, mem_we}, 32'd0);
    wait_idle();

    // back-to-back plots
    for (int i = 10; i < 14; i++) send(i, 0, i % 8);
    idle();
    wait_idle();

    // clear with two requests in flight: both are flushed, never written
    in_x = 8'd7; in_y = 7'd7; in_colour = 3'd6; in_plot = 1'b1;
    @(negedge clk);
    in_x = 8'd8; clear_req = 1'b1; clear_colour = 3'd2;
    @(negedge clk);
    in_plot = 1'b0; clear_req = 1'b0;
    wait_idle();

    // fill the FIFO during a clear; queued plots follow the last sweep write
    clear_req = 1'b1; clear_colour = 3'd3;
    @(negedge clk);
    clear_req = 1'b0;
    for (int i = 0; i < 8; i++) send(20 + i, 5, i);
    chk("t4_full", {31'd0, in_ready}, 32'd0);
    for (int i = 8; i < 10; i++) send(20 + i, 5, i);
    idle();
    wait_idle();

    // reset in the middle of a sweep
    clear_req = 1'b1; clear_colour = 3'd4;
    @(negedge clk);
    clear_req = 1'b0;
    for (int i = 0; i < 3; i++) send(i, 9, 1);
    idle();
    repeat (4997) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("t5_we",    {31'd0, mem_we},   32'd0);
    chk("t5_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_busy",  {31'd0, busy},     32'd0);
    @(negedge clk);

    // off-screen coordinates
    send(160, 0, 1);
    send(0, 120, 2);
    idle();
    wait_idle();
`ifdef PWB_CLIP_EN
    chk("t6_clip", {24'd0, clip_count}, 32'd2);
`else
    chk("t6_clip", {24'd0, clip_count}, 32'd0);
`endif

    // randomized plots with random gaps
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(negedge clk);
      end else begin
        send($urandom_range(0, 199), $urandom_range(0, 127), $urandom_range(0, 7));
      end
    end
    idle();
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
